// File: rtl/systolic_feed_ctrl_if.sv
// Host/array-side bundle for systolic_feed_ctrl: operand/weight write port, start/busy,
// array feeds, bottom-edge return and valid/ready result port. Optional SYSTOLIC_PERF_EN adds perf_cycles.
interface systolic_feed_ctrl_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4
);
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   logic                           wr_en;
   logic                           wr_sel;
   logic [IDX_W-1:0]               wr_row;
   logic [IDX_W-1:0]               wr_col;
   logic [WIDTH-1:0]               wr_data;
   logic                           start;
   logic                           busy;
   logic                           array_rst;
   logic [N-1:0][WIDTH-1:0]        in_up;
   logic [N-1:0][WIDTH-1:0]        in_left;
   logic [N-1:0][N-1:0][WIDTH-1:0] weights;
   logic [N-1:0][WIDTH-1:0]        out_down;
   logic [N-1:0][WIDTH-1:0]        res_data;
   logic                           res_valid;
   logic                           res_ready;
`ifdef SYSTOLIC_PERF_EN
   logic [31:0]                    perf_cycles;

   modport slave (
      input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, out_down, res_ready,
      output busy, array_rst, in_up, in_left, weights, res_data, res_valid, perf_cycles
   );
   modport master (
      output wr_en, wr_sel, wr_row, wr_col, wr_data, start, out_down, res_ready,
      input  busy, array_rst, in_up, in_left, weights, res_data, res_valid, perf_cycles
   );
`else
   modport slave (
      input  wr_en, wr_sel, wr_row, wr_col, wr_data, start, out_down, res_ready,
      output busy, array_rst, in_up, in_left, weights, res_data, res_valid
   );
   modport master (
      output wr_en, wr_sel, wr_row, wr_col, wr_data, start, out_down, res_ready,
      input  busy, array_rst, in_up, in_left, weights, res_data, res_valid
   );
`endif
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for the NxN systolic array: buffers A and W, clears the array, feeds A column-skewed,
// drains, captures out_down and returns it over valid/ready. Macro SYSTOLIC_PERF_EN adds a busy-cycle counter.
module systolic_feed_ctrl #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned N         = 4,
   parameter int unsigned DRAIN_CYC = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   systolic_feed_ctrl_if.slave  bus
);
   localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W    = $clog2(2*N - 1 + DRAIN_CYC) + 1;
   localparam int unsigned FEED_LEN = 2*N - 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE, S_RESULT
   } state_t;

   state_t                         r_state;
   logic [CNT_W-1:0]               r_beat;
   logic [N-1:0][N-1:0][WIDTH-1:0] r_a;
   logic [N-1:0][N-1:0][WIDTH-1:0] r_w;
   logic [N-1:0][WIDTH-1:0]        r_in_up;
   logic [N-1:0][WIDTH-1:0]        r_res_data;
   logic                           r_busy;
   logic                           r_array_rst;
   logic                           r_res_valid;

   logic [CNT_W-1:0]               w_feed_idx;
   logic [N-1:0][CNT_W-1:0]        w_diff;
   logic [N-1:0][WIDTH-1:0]        w_skew;
   logic                           w_wr_ok;

   // Skewed beat: column c carries row (t-c); a wrapped (negative) difference falls out of range.
   always_comb begin
      w_feed_idx = (r_state == S_FEED) ? r_beat : '0;
      w_diff     = '0;
      w_skew     = '0;
      for (int c = 0; c < int'(N); c++) begin
         w_diff[c] = w_feed_idx - CNT_W'(c);
         if (w_diff[c] < CNT_W'(N)) begin
            w_skew[c] = r_a[w_diff[c][IDX_W-1:0]][c];
         end
      end
   end

   assign w_wr_ok = bus.wr_en && (32'(bus.wr_row) < N) && (32'(bus.wr_col) < N);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_a         <= '0;
         r_w         <= '0;
         r_in_up     <= '0;
         r_res_data  <= '0;
         r_busy      <= 1'b0;
         r_array_rst <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_array_rst <= 1'b1;
               if (w_wr_ok) begin
                  if (bus.wr_sel) r_w[bus.wr_row][bus.wr_col] <= bus.wr_data;
                  else            r_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
               end
               if (bus.start) begin
                  r_state     <= S_CLEAR;
                  r_busy      <= 1'b1;
                  r_array_rst <= 1'b0;
               end
            end
            S_CLEAR: begin
               r_state     <= S_FEED;
               r_array_rst <= 1'b1;
               r_in_up     <= w_skew;
               r_beat      <= CNT_W'(1);
            end
            S_FEED: begin
               if (r_beat == CNT_W'(FEED_LEN)) begin
                  r_state <= S_DRAIN;
                  r_in_up <= '0;
                  r_beat  <= CNT_W'(1);
               end else begin
                  r_in_up <= w_skew;
                  r_beat  <= r_beat + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (r_beat == CNT_W'(DRAIN_CYC)) begin
                  r_state <= S_CAPTURE;
               end else begin
                  r_beat <= r_beat + CNT_W'(1);
               end
            end
            S_CAPTURE: begin
               r_state     <= S_RESULT;
               r_res_data  <= bus.out_down;
               r_res_valid <= 1'b1;
            end
            S_RESULT: begin
               if (bus.res_ready) begin
                  r_state     <= S_IDLE;
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SYSTOLIC_PERF_EN
   logic [31:0] r_perf;

   // Cumulative busy cycles, including result stalls; wraps naturally.
   always_ff @(posedge i_clk) begin
      if (!i_rst)      r_perf <= '0;
      else if (r_busy) r_perf <= r_perf + 32'd1;
   end

   assign bus.perf_cycles = r_perf;
`endif

   assign bus.busy      = r_busy;
   assign bus.array_rst = r_array_rst;
   assign bus.in_up     = r_in_up;
   assign bus.in_left   = '0;
   assign bus.weights   = r_w;
   assign bus.res_data  = r_res_data;
   assign bus.res_valid = r_res_valid;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: reset/write vector table, then directed and
// randomized runs against a cycle-offset reference model of the feed/result sequence.
module tb_systolic_feed_ctrl;
   localparam int unsigned WIDTH     = 16;
   localparam int unsigned N         = 4;
   localparam int unsigned DRAIN_CYC = 4;
   localparam int unsigned IDX_W     = $clog2(N);
   localparam int unsigned CAP_OFF   = 2*N + DRAIN_CYC + 1;
   localparam int unsigned CW        = N*N*WIDTH;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_feed_ctrl_if #(.WIDTH(WIDTH), .N(N)) bus ();

   systolic_feed_ctrl #(.WIDTH(WIDTH), .N(N), .DRAIN_CYC(DRAIN_CYC)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] m_perf = '0;
   bit          cur_busy = 1'b0;
   logic [WIDTH-1:0] ma [N][N];
   logic [WIDTH-1:0] mw [N][N];
   int lit [7][4] = '{'{1,0,0,0}, '{5,2,0,0}, '{9,6,3,0}, '{13,10,7,4},
                      '{0,14,11,8}, '{0,0,15,12}, '{0,0,0,16}};

   typedef struct {
      logic             rst_n;
      logic             wr_en;
      logic             wr_sel;
      logic [IDX_W-1:0] row;
      logic [IDX_W-1:0] col;
      logic [WIDTH-1:0] data;
      logic             start;
      logic             exp_busy;
      logic             exp_arst;
      logic [WIDTH-1:0] exp_w01;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      if (cur_busy) m_perf++;
      @(posedge clk);
      #1;
      if (!rst_n) m_perf = '0;
   endtask

   function automatic logic [CW-1:0] pack_w();
      logic [N-1:0][N-1:0][WIDTH-1:0] v;
      for (int r = 0; r < int'(N); r++)
         for (int c = 0; c < int'(N); c++) v[r][c] = mw[r][c];
      return CW'(v);
   endfunction

   // Expected top-edge feed for a given cycle offset after the start edge.
   function automatic logic [CW-1:0] exp_in_up(input int off, input bit literal);
      logic [N-1:0][WIDTH-1:0] v;
      int t;
      v = '0;
      t = off - 2;
      if (off >= 2 && off <= int'(2*N)) begin
         for (int c = 0; c < int'(N); c++) begin
            if (literal) v[c] = WIDTH'(lit[t][c]);
            else if (t - c >= 0 && t - c < int'(N)) v[c] = ma[t-c][c];
         end
      end
      return CW'(v);
   endfunction

   task automatic clear_model();
      for (int r = 0; r < int'(N); r++)
         for (int c = 0; c < int'(N); c++) begin
            ma[r][c] = '0;
            mw[r][c] = '0;
         end
   endtask

   task automatic wr(input bit sel, input int r, input int c, input logic [WIDTH-1:0] d);
      bus.wr_en  = 1'b1;
      bus.wr_sel = sel;
      bus.wr_row = IDX_W'(r);
      bus.wr_col = IDX_W'(c);
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
      if (sel) mw[r][c] = d;
      else     ma[r][c] = d;
   endtask

   task automatic run(input bit reload, input bit literal, input int stall,
                      input int abort_off, input bit poke);
      logic [N-1:0][WIDTH-1:0] cap;
      cap = '0;
      if (reload) begin
         for (int r = 0; r < int'(N); r++)
            for (int c = 0; c < int'(N); c++) begin
               wr(1'b0, r, c, literal ? WIDTH'(r*N + c + 1) : WIDTH'($urandom));
               wr(1'b1, r, c, literal ? WIDTH'(r + c + 1) : WIDTH'($urandom));
            end
      end
      chk("weights_pre_run", CW'(bus.weights), pack_w());
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cur_busy = 1'b1;
      for (int off = 1; off <= int'(CAP_OFF); off++) begin
         chk($sformatf("in_up_off%0d", off), CW'(bus.in_up), exp_in_up(off, literal));
         chk($sformatf("busy_off%0d", off), CW'(bus.busy), CW'(1));
         chk($sformatf("arst_off%0d", off), CW'(bus.array_rst), CW'(off != 1));
         chk($sformatf("valid_off%0d", off), CW'(bus.res_valid), CW'(0));
         if (off == abort_off) begin
            rst_n = 1'b0;
            tick();
            cur_busy = 1'b0;
            clear_model();
            chk("abort_busy", CW'(bus.busy), CW'(0));
            chk("abort_in_up", CW'(bus.in_up), CW'(0));
            chk("abort_arst", CW'(bus.array_rst), CW'(0));
            chk("abort_weights", CW'(bus.weights), pack_w());
            rst_n = 1'b1;
            tick();
            return;
         end
         if (poke) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_sel  = 1'($urandom_range(0, 1));
            bus.wr_row  = '0;
            bus.wr_col  = '0;
            bus.wr_data = WIDTH'(99);
            bus.start   = 1'($urandom_range(0, 1));
         end
         bus.out_down = (N*WIDTH)'({$urandom, $urandom});
         if (off == int'(CAP_OFF)) cap = bus.out_down;
         tick();
         bus.wr_en = 1'b0;
         bus.start = 1'b0;
      end
      for (int s = 0; s <= stall; s++) begin
         chk("res_valid", CW'(bus.res_valid), CW'(1));
         chk("res_data", CW'(bus.res_data), CW'(cap));
         chk("res_busy", CW'(bus.busy), CW'(1));
         bus.out_down  = (N*WIDTH)'({$urandom, $urandom});
         bus.res_ready = (s == stall);
         bus.start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         if (s == stall) bus.start = poke;
         tick();
      end
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      cur_busy      = 1'b0;
      chk("post_hs_valid", CW'(bus.res_valid), CW'(0));
      chk("post_hs_busy", CW'(bus.busy), CW'(0));
      tick();
      chk("idle_stays_idle", CW'(bus.busy), CW'(0));
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
      bus.wr_data = '0; bus.start = 1'b0; bus.out_down = '0; bus.res_ready = 1'b0;
      clear_model();

      //          rst we sel row col data      st busy arst w01
      tbl[0] = '{1'b0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000};
      tbl[1] = '{1'b0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000};
      tbl[2] = '{1'b0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000};
      tbl[3] = '{1'b1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000};
      tbl[4] = '{1'b1, 1, 1, 0, 1, 16'h1234, 0, 0, 1, 16'h1234};
      tbl[5] = '{1'b1, 1, 0, 0, 1, 16'h0005, 0, 0, 1, 16'h1234};
      tbl[6] = '{1'b1, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
      tbl[7] = '{1'b1, 1, 1, 0, 1, 16'h5555, 0, 1, 1, 16'h1234};
      tbl[8] = '{1'b0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000};

      for (int i = 0; i < 9; i++) begin
         rst_n       = tbl[i].rst_n;
         bus.wr_en   = tbl[i].wr_en;
         bus.wr_sel  = tbl[i].wr_sel;
         bus.wr_row  = tbl[i].row;
         bus.wr_col  = tbl[i].col;
         bus.wr_data = tbl[i].data;
         bus.start   = tbl[i].start;
         tick();
         cur_busy = tbl[i].exp_busy;
         chk($sformatf("tbl%0d_busy", i), CW'(bus.busy), CW'(tbl[i].exp_busy));
         chk($sformatf("tbl%0d_arst", i), CW'(bus.array_rst), CW'(tbl[i].exp_arst));
         chk($sformatf("tbl%0d_w01", i), CW'(bus.weights[0][1]), CW'(tbl[i].exp_w01));
         if (!tbl[i].rst_n) begin
            chk($sformatf("tbl%0d_in_up", i), CW'(bus.in_up), CW'(0));
            chk($sformatf("tbl%0d_valid", i), CW'(bus.res_valid), CW'(0));
         end
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("idle_arst", CW'(bus.array_rst), CW'(1));
      chk("in_left_zero", CW'(bus.in_left), CW'(0));

      run(1'b1, 1'b1, 0, -1, 1'b0);
      run(1'b1, 1'b0, 10, -1, 1'b1);
      run(1'b0, 1'b0, 3, -1, 1'b1);
      run(1'b1, 1'b0, 0, 5, 1'b0);
      run(1'b1, 1'b0, 2, -1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         run(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 6)), -1, 1'b1);
      end
`ifdef SYSTOLIC_PERF_EN
      chk("perf_cycles", CW'(bus.perf_cycles), CW'(m_perf));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
